// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the memory controller: FSM states, goal codes,
// IO window match value and the latched request record.
package memory_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [2:0] GOAL_LB   = 3'd1;
    localparam logic [2:0] GOAL_LH   = 3'd2;
    localparam logic [2:0] GOAL_LW   = 3'd4;
    localparam logic [1:0] IO_WINDOW = 2'b11;
    localparam logic       FALSE     = 1'b0;
    localparam logic       TRUE      = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [2:0]  goal;
        logic [31:0] data;
    } req_t;

    // Byte idx of a little-endian word.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [2:0] idx);
        return word[{idx[1:0], 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Client request/response signals and the 8-bit RAM bus of the memory controller.
interface memory_controller_if;
    logic        lsb_request_in;
    logic        lsb_rw_signal_in;
    logic [31:0] lsb_address_in;
    logic [2:0]  lsb_goal_in;
    logic [31:0] lsb_data_in;
    logic        lsb_ready_out;
    logic [31:0] lsb_data_out;
    logic        if_request_in;
    logic [31:0] if_address_in;
    logic        if_ready_out;
    logic [31:0] if_data_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        input  if_request_in, if_address_in, mem_din,
        output lsb_ready_out, lsb_data_out, if_ready_out, if_data_out,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        output if_request_in, if_address_in, mem_din,
        input  lsb_ready_out, lsb_data_out, if_ready_out, if_data_out,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/memory_controller_arbiter.sv
// mc_arbiter: per-client pending latches plus fixed-priority (LSB first) grant.
// A pulse arriving while idle with nothing pending is granted combinationally.
module mc_arbiter
    import memory_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rollback,
    input  logic        idle,
    input  logic        lsb_request,
    input  req_t        lsb_req,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    output logic        grant_lsb,
    output logic        grant_if,
    output req_t        sel_req
);
    logic        lsb_pend_reg;
    req_t        lsb_req_reg;
    logic        if_pend_reg;
    logic [31:0] if_addr_reg;

    logic        lsb_take;
    logic        if_take;
    logic        lsb_eff;
    logic        if_eff;
    req_t        lsb_cur;
    logic [31:0] if_cur;

    always_comb begin
        lsb_take  = lsb_request & ~rollback & ~lsb_pend_reg;
        if_take   = if_request & ~rollback & ~if_pend_reg;
        // A pending store survives a rollback; pending loads and fetches do not.
        lsb_eff   = (lsb_pend_reg & (lsb_req_reg.rw | ~rollback)) | lsb_take;
        if_eff    = (if_pend_reg & ~rollback) | if_take;
        lsb_cur   = lsb_pend_reg ? lsb_req_reg : lsb_req;
        if_cur    = if_pend_reg ? if_addr_reg : if_addr;
        grant_lsb = idle & lsb_eff;
        grant_if  = idle & if_eff & ~lsb_eff;
        sel_req   = lsb_cur;
        if (grant_if) begin
            sel_req = '{addr: if_cur, rw: FALSE, goal: GOAL_LW, data: 32'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_pend_reg <= FALSE;
            lsb_req_reg  <= '0;
            if_pend_reg  <= FALSE;
            if_addr_reg  <= '0;
        end else begin
            lsb_pend_reg <= lsb_eff & ~grant_lsb;
            if_pend_reg  <= if_eff & ~grant_if;
            if (lsb_take) lsb_req_reg <= lsb_req;
            if (if_take)  if_addr_reg <= if_addr;
        end
    end
endmodule

// File: rtl/memory_controller.sv
// Single-port RAM sequencer: splits granted 1/2/4-byte accesses into byte cycles.
// Define MC_IO_STALL_EN to hold store bytes to the IO window while io_buffer_full.
module memory_controller
    import memory_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rob_rollback_in,
    input  logic                io_buffer_full,
    memory_controller_if.slave  bus
);
    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [2:0]  n_reg, n_next;
    logic [31:0] base_reg, base_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        is_if_reg, is_if_next;
    logic [31:0] rbuf_reg, rbuf_next;
    logic [31:0] mem_a_reg, mem_a_next;
    logic [7:0]  mem_dout_reg, mem_dout_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        lsb_ready_reg, lsb_ready_next;
    logic        if_ready_reg, if_ready_next;
    logic [31:0] lsb_data_reg, lsb_data_next;
    logic [31:0] if_data_reg, if_data_next;

    logic        grant_lsb;
    logic        grant_if;
    req_t        sel_req;
    req_t        lsb_req_in;
    logic [31:0] act_base;
    logic [31:0] act_wdata;
    logic [2:0]  act_idx;
    logic [31:0] byte_addr;
    logic [31:0] rd_word;
    logic        io_stall;

    assign lsb_req_in = '{addr: bus.lsb_address_in, rw: bus.lsb_rw_signal_in,
                          goal: bus.lsb_goal_in, data: bus.lsb_data_in};

    mc_arbiter u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .rollback    (rob_rollback_in),
        .idle        (state_reg == ST_IDLE),
        .lsb_request (bus.lsb_request_in),
        .lsb_req     (lsb_req_in),
        .if_request  (bus.if_request_in),
        .if_addr     (bus.if_address_in),
        .grant_lsb   (grant_lsb),
        .grant_if    (grant_if),
        .sel_req     (sel_req)
    );

    // In IDLE the byte being issued is byte 0 of the request granted this edge.
    always_comb begin
        act_base  = base_reg;
        act_wdata = wdata_reg;
        act_idx   = cnt_reg;
        if (state_reg == ST_IDLE) begin
            act_base  = sel_req.addr;
            act_wdata = sel_req.data;
            act_idx   = 3'd0;
        end
        byte_addr = act_base + {29'd0, act_idx};
        rd_word   = rbuf_reg | ({24'd0, bus.mem_din} << {cnt_reg - 3'd2, 3'b000});
    end

`ifdef MC_IO_STALL_EN
    assign io_stall = (byte_addr[17:16] == IO_WINDOW) && io_buffer_full;
`else
    logic io_full_unused;
    assign io_full_unused = io_buffer_full;
    assign io_stall       = FALSE;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        n_next         = n_reg;
        base_next      = base_reg;
        wdata_next     = wdata_reg;
        is_if_next     = is_if_reg;
        rbuf_next      = rbuf_reg;
        mem_a_next     = 32'd0;
        mem_dout_next  = 8'd0;
        mem_wr_next    = FALSE;
        lsb_ready_next = FALSE;
        if_ready_next  = FALSE;
        lsb_data_next  = lsb_data_reg;
        if_data_next   = if_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_lsb || grant_if) begin
                    base_next  = sel_req.addr;
                    n_next     = sel_req.goal;
                    wdata_next = sel_req.data;
                    is_if_next = grant_if;
                    rbuf_next  = 32'd0;
                    cnt_next   = 3'd1;
                    if (grant_lsb && sel_req.rw) begin
                        state_next = ST_WRITE;
                        if (io_stall) begin
                            cnt_next = 3'd0;
                        end else begin
                            mem_a_next    = byte_addr;
                            mem_dout_next = byte_of(act_wdata, act_idx);
                            mem_wr_next   = TRUE;
                        end
                    end else begin
                        state_next = ST_READ;
                        mem_a_next = byte_addr;
                    end
                end
            end
            ST_READ: begin
                if (rob_rollback_in) begin
                    state_next = ST_IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    // cnt_reg counts edges since grant; byte cnt-2 arrives now.
                    if (cnt_reg < n_reg)  mem_a_next = byte_addr;
                    if (cnt_reg >= 3'd2) rbuf_next  = rd_word;
                    if ({1'b0, cnt_reg} == {1'b0, n_reg} + 4'd1) begin
                        state_next = ST_IDLE;
                        cnt_next   = 3'd0;
                        if (is_if_reg) begin
                            if_ready_next = TRUE;
                            if_data_next  = rd_word;
                        end else begin
                            lsb_ready_next = TRUE;
                            lsb_data_next  = rd_word;
                        end
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_reg < n_reg) begin
                    if (!io_stall) begin
                        mem_a_next    = byte_addr;
                        mem_dout_next = byte_of(act_wdata, act_idx);
                        mem_wr_next   = TRUE;
                        cnt_next      = cnt_reg + 3'd1;
                    end
                end else begin
                    lsb_ready_next = TRUE;
                    state_next     = ST_IDLE;
                    cnt_next       = 3'd0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 3'd0;
            n_reg         <= 3'd0;
            base_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            is_if_reg     <= FALSE;
            rbuf_reg      <= 32'd0;
            mem_a_reg     <= 32'd0;
            mem_dout_reg  <= 8'd0;
            mem_wr_reg    <= FALSE;
            lsb_ready_reg <= FALSE;
            if_ready_reg  <= FALSE;
            lsb_data_reg  <= 32'd0;
            if_data_reg   <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            n_reg         <= n_next;
            base_reg      <= base_next;
            wdata_reg     <= wdata_next;
            is_if_reg     <= is_if_next;
            rbuf_reg      <= rbuf_next;
            mem_a_reg     <= mem_a_next;
            mem_dout_reg  <= mem_dout_next;
            mem_wr_reg    <= mem_wr_next;
            lsb_ready_reg <= lsb_ready_next;
            if_ready_reg  <= if_ready_next;
            lsb_data_reg  <= lsb_data_next;
            if_data_reg   <= if_data_next;
        end
    end

    assign bus.mem_a         = mem_a_reg;
    assign bus.mem_dout      = mem_dout_reg;
    assign bus.mem_wr        = mem_wr_reg;
    assign bus.lsb_ready_out = lsb_ready_reg;
    assign bus.lsb_data_out  = lsb_data_reg;
    assign bus.if_ready_out  = if_ready_reg;
    assign bus.if_data_out   = if_data_reg;
endmodule

// File: tb/tb_memory_controller.sv
// Directed testbench for memory_controller with a synchronous byte RAM model.
// Covers the IO stall path when built with MC_IO_STALL_EN.
module tb_memory_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rollback = 1'b0;
    logic io_full = 1'b0;

    memory_controller_if bus();

    memory_controller dut (
        .clk             (clk),
        .rst             (rst),
        .rob_rollback_in (rollback),
        .io_buffer_full  (io_full),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];

    // RAM model: read data one cycle after the address, writes on mem_wr.
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[15:0]];
        if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end

    // Protocol monitor: no second pulse while the same client is outstanding.
    logic lsb_busy, lsb_busy_rw, if_busy;
    always @(posedge clk) begin
        if (rst) begin
            lsb_busy    <= 1'b0;
            lsb_busy_rw <= 1'b0;
            if_busy     <= 1'b0;
        end else begin
            if (bus.lsb_request_in) assert (!lsb_busy || bus.lsb_ready_out) else $error("protocol: lsb pulse while busy");
            if (bus.if_request_in)  assert (!if_busy || bus.if_ready_out) else $error("protocol: if pulse while busy");
            if (bus.lsb_request_in && !rollback) begin
                lsb_busy    <= 1'b1;
                lsb_busy_rw <= bus.lsb_rw_signal_in;
            end else if (bus.lsb_ready_out || (rollback && !lsb_busy_rw)) begin
                lsb_busy <= 1'b0;
            end
            if (bus.if_request_in && !rollback) if_busy <= 1'b1;
            else if (bus.if_ready_out || rollback) if_busy <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    // Per-test observation log; tick_no k is the cycle after edge k (edge 0 = first request edge).
    int          tick_no;
    logic [31:0] a_log [0:31];
    int          lsb_cnt, lsb_at, if_cnt, if_at, wr_cnt, wr_first;
    logic [31:0] wr_a [0:7];
    logic [7:0]  wr_d [0:7];

    task automatic clear_log();
        tick_no = -1; lsb_cnt = 0; lsb_at = -1; if_cnt = 0; if_at = -1; wr_cnt = 0; wr_first = -1;
        for (int i = 0; i < 32; i++) a_log[i] = 32'hx;
    endtask

    task automatic step();
        @(posedge clk); #1;
        tick_no++;
        if (tick_no >= 0 && tick_no < 32) a_log[tick_no] = bus.mem_a;
        if (bus.lsb_ready_out) begin lsb_cnt++; lsb_at = tick_no; end
        if (bus.if_ready_out)  begin if_cnt++;  if_at = tick_no;  end
        if (bus.mem_wr) begin
            if (wr_cnt == 0) wr_first = tick_no;
            if (wr_cnt < 8) begin wr_a[wr_cnt] = bus.mem_a; wr_d[wr_cnt] = bus.mem_dout; end
            wr_cnt++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lsb_set(input logic rw, input logic [31:0] addr, input logic [2:0] goal, input logic [31:0] data);
        bus.lsb_request_in = 1'b1; bus.lsb_rw_signal_in = rw;
        bus.lsb_address_in = addr; bus.lsb_goal_in = goal; bus.lsb_data_in = data;
    endtask

    task automatic if_set(input logic [31:0] addr);
        bus.if_request_in = 1'b1; bus.if_address_in = addr;
    endtask

    task automatic test_reset();
        rst = 1'b1; steps(3);
        n_checks++; if (bus.mem_a !== 32'd0) $display("FAIL reset_mem_a got %h want 0", bus.mem_a); else n_pass++;
        n_checks++; if (bus.mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); else n_pass++;
        n_checks++; if (bus.mem_dout !== 8'd0) $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); else n_pass++;
        n_checks++; if (bus.lsb_ready_out !== 1'b0 || bus.if_ready_out !== 1'b0) $display("FAIL reset_ready got %b%b want 00", bus.lsb_ready_out, bus.if_ready_out); else n_pass++;
        n_checks++; if (bus.lsb_data_out !== 32'd0 || bus.if_data_out !== 32'd0) $display("FAIL reset_data got %h/%h want 0/0", bus.lsb_data_out, bus.if_data_out); else n_pass++;
        rst = 1'b0; steps(2);
        $display("reset done");
    endtask

    task automatic test_fetch();
        clear_log();
        if_set(32'h4); step(); bus.if_request_in = 1'b0; steps(7);
        $display("fetch @00000004 -> %h ready at %0d", bus.if_data_out, if_at);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (a_log[k] !== 32'h4 + k) $display("FAIL fetch_addr%0d got %h want %h", k, a_log[k], 32'h4 + k); else n_pass++;
        end
        n_checks++; if (if_at !== 5 || if_cnt !== 1) $display("FAIL fetch_ready got at=%0d cnt=%0d want at=5 cnt=1", if_at, if_cnt); else n_pass++;
        n_checks++; if (bus.if_data_out !== 32'h00100513) $display("FAIL fetch_data got %h want 00100513", bus.if_data_out); else n_pass++;
        n_checks++; if (wr_cnt !== 0 || lsb_cnt !== 0) $display("FAIL fetch_side got wr=%0d lsb=%0d want 0/0", wr_cnt, lsb_cnt); else n_pass++;
    endtask

    task automatic test_loads();
        clear_log();
        lsb_set(1'b0, 32'h1000, 3'd2, 32'h0); step(); bus.lsb_request_in = 1'b0; steps(5);
        $display("LH @00001000 -> %h ready at %0d", bus.lsb_data_out, lsb_at);
        n_checks++; if (lsb_at !== 3 || lsb_cnt !== 1) $display("FAIL lh_ready got at=%0d cnt=%0d want at=3 cnt=1", lsb_at, lsb_cnt); else n_pass++;
        n_checks++; if (bus.lsb_data_out !== 32'h00001234) $display("FAIL lh_data got %h want 00001234", bus.lsb_data_out); else n_pass++;
        clear_log();
        lsb_set(1'b0, 32'h1003, 3'd1, 32'h0); step(); bus.lsb_request_in = 1'b0; steps(4);
        $display("LB @00001003 -> %h ready at %0d", bus.lsb_data_out, lsb_at);
        n_checks++; if (lsb_at !== 2 || lsb_cnt !== 1) $display("FAIL lb_ready got at=%0d cnt=%0d want at=2 cnt=1", lsb_at, lsb_cnt); else n_pass++;
        n_checks++; if (bus.lsb_data_out !== 32'h000000F0) $display("FAIL lb_data got %h want 000000f0", bus.lsb_data_out); else n_pass++;
    endtask

    task automatic test_store();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        clear_log();
        lsb_set(1'b1, 32'h2000, 3'd4, 32'hDEADBEEF); step(); bus.lsb_request_in = 1'b0; steps(6);
        $display("SW @00002000 deadbeef: %0d writes, ready at %0d", wr_cnt, lsb_at);
        n_checks++; if (wr_cnt !== 4 || wr_first !== 0) $display("FAIL sw_wr got cnt=%0d first=%0d want 4/0", wr_cnt, wr_first); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wr_a[k] !== 32'h2000 + k || wr_d[k] !== exp_b[k]) $display("FAIL sw_byte%0d got %h:%h want %h:%h", k, wr_a[k], wr_d[k], 32'h2000 + k, exp_b[k]);
            else n_pass++;
        end
        n_checks++; if (lsb_at !== 4 || lsb_cnt !== 1) $display("FAIL sw_ready got at=%0d cnt=%0d want 4/1", lsb_at, lsb_cnt); else n_pass++;
        clear_log();
        lsb_set(1'b0, 32'h2000, 3'd4, 32'h0); step(); bus.lsb_request_in = 1'b0; steps(6);
        $display("LW @00002000 -> %h", bus.lsb_data_out);
        n_checks++; if (bus.lsb_data_out !== 32'hDEADBEEF || lsb_at !== 5) $display("FAIL lw_back got %h at %0d want deadbeef at 5", bus.lsb_data_out, lsb_at); else n_pass++;
        clear_log();
        lsb_set(1'b1, 32'hFFFFFFFF, 3'd2, 32'h0000CDAB); step(); bus.lsb_request_in = 1'b0; steps(4);
        $display("SH @ffffffff cdab: %0d writes", wr_cnt);
        n_checks++;
        if (wr_cnt !== 2 || wr_a[0] !== 32'hFFFFFFFF || wr_d[0] !== 8'hAB || wr_a[1] !== 32'h0 || wr_d[1] !== 8'hCD)
            $display("FAIL sh_wrap got %0d %h:%h %h:%h want 2 ffffffff:ab 00000000:cd", wr_cnt, wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
        else n_pass++;
        n_checks++; if (lsb_at !== 2) $display("FAIL sh_wrap_ready got %0d want 2", lsb_at); else n_pass++;
    endtask

    task automatic test_both();
        clear_log();
        lsb_set(1'b0, 32'h1003, 3'd1, 32'h0); if_set(32'h4); step();
        bus.lsb_request_in = 1'b0; bus.if_request_in = 1'b0; steps(10);
        $display("LB+fetch same cycle: lsb ready %0d, if ready %0d", lsb_at, if_at);
        n_checks++; if (lsb_at !== 2) $display("FAIL both_lsb_ready got %0d want 2", lsb_at); else n_pass++;
        n_checks++; if (a_log[3] !== 32'h4 || a_log[2] !== 32'h0) $display("FAIL both_if_grant got %h/%h want 0/4", a_log[2], a_log[3]); else n_pass++;
        n_checks++; if (if_at !== 8 || bus.if_data_out !== 32'h00100513) $display("FAIL both_if_ready got %0d %h want 8 00100513", if_at, bus.if_data_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        if_set(32'h4); step(); bus.if_request_in = 1'b0; steps(4);
        lsb_set(1'b0, 32'h1003, 3'd1, 32'h0); step(); bus.lsb_request_in = 1'b0; steps(5);
        $display("fetch then LB on ready edge: if ready %0d, lsb ready %0d", if_at, lsb_at);
        n_checks++; if (a_log[5] !== 32'h0 || a_log[6] !== 32'h1003) $display("FAIL b2b_grant got %h/%h want 0/1003", a_log[5], a_log[6]); else n_pass++;
        n_checks++; if (if_at !== 5 || lsb_at !== 8) $display("FAIL b2b_ready got if=%0d lsb=%0d want 5/8", if_at, lsb_at); else n_pass++;
    endtask

    task automatic test_rollback();
        clear_log();
        if_set(32'h4); step(); bus.if_request_in = 1'b0;
        lsb_set(1'b1, 32'h2800, 3'd2, 32'h00005AA5); step(); bus.lsb_request_in = 1'b0;
        rollback = 1'b1; step(); rollback = 1'b0;
        steps(9);
        $display("rollback mid-fetch, SH pending: if ready cnt %0d, %0d writes, lsb ready %0d", if_cnt, wr_cnt, lsb_at);
        n_checks++; if (if_cnt !== 0) $display("FAIL rb_no_if_ready got %0d want 0", if_cnt); else n_pass++;
        n_checks++; if (a_log[2] !== 32'h0) $display("FAIL rb_idle_addr got %h want 0", a_log[2]); else n_pass++;
        n_checks++;
        if (wr_cnt !== 2 || wr_first !== 3 || wr_a[0] !== 32'h2800 || wr_d[0] !== 8'hA5 || wr_a[1] !== 32'h2801 || wr_d[1] !== 8'h5A)
            $display("FAIL rb_sh_writes got %0d@%0d %h:%h %h:%h want 2@3 2800:a5 2801:5a", wr_cnt, wr_first, wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
        else n_pass++;
        n_checks++; if (lsb_at !== 5 || lsb_cnt !== 1) $display("FAIL rb_sh_ready got at=%0d cnt=%0d want 5/1", lsb_at, lsb_cnt); else n_pass++;
    endtask

    task automatic test_io_stall();
        clear_log();
        io_full = 1'b1;
        lsb_set(1'b1, 32'h00030000, 3'd1, 32'h00000041); step(); bus.lsb_request_in = 1'b0;
        steps(2); io_full = 1'b0; steps(4);
        $display("SB 41 @00030000 with io full 3 cycles: write at %0d, ready at %0d", wr_first, lsb_at);
`ifdef MC_IO_STALL_EN
        n_checks++; if (wr_cnt !== 1 || wr_first !== 3) $display("FAIL io_stall_wr got cnt=%0d at=%0d want 1/3", wr_cnt, wr_first); else n_pass++;
        n_checks++; if (lsb_at !== 4) $display("FAIL io_stall_ready got %0d want 4", lsb_at); else n_pass++;
`else
        n_checks++; if (wr_cnt !== 1 || wr_first !== 0) $display("FAIL io_ignored_wr got cnt=%0d at=%0d want 1/0", wr_cnt, wr_first); else n_pass++;
        n_checks++; if (lsb_at !== 1) $display("FAIL io_ignored_ready got %0d want 1", lsb_at); else n_pass++;
`endif
        n_checks++; if (wr_a[0] !== 32'h00030000 || wr_d[0] !== 8'h41) $display("FAIL io_byte got %h:%h want 00030000:41", wr_a[0], wr_d[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        lsb_set(1'b1, 32'h2400, 3'd4, 32'h11223344); step(); bus.lsb_request_in = 1'b0;
        step(); rst = 1'b1; step();
        $display("reset mid-store after %0d writes", wr_cnt);
        n_checks++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0) $display("FAIL rstmid_bus got %b %h %h want 0 0 0", bus.mem_wr, bus.mem_a, bus.mem_dout); else n_pass++;
        n_checks++; if (bus.lsb_data_out !== 32'h0 || bus.if_data_out !== 32'h0) $display("FAIL rstmid_data got %h/%h want 0/0", bus.lsb_data_out, bus.if_data_out); else n_pass++;
        rst = 1'b0; steps(6);
        n_checks++; if (wr_cnt !== 2 || lsb_cnt !== 0) $display("FAIL rstmid_abandon got wr=%0d ready=%0d want 2/0", wr_cnt, lsb_cnt); else n_pass++;
    endtask

    initial begin
        bus.lsb_request_in = 1'b0; bus.lsb_rw_signal_in = 1'b0; bus.lsb_address_in = '0;
        bus.lsb_goal_in = 3'd0; bus.lsb_data_in = '0; bus.if_request_in = 1'b0; bus.if_address_in = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0004] = 8'h13; ram[16'h0005] = 8'h05; ram[16'h0006] = 8'h10; ram[16'h0007] = 8'h00;
        ram[16'h1000] = 8'h34; ram[16'h1001] = 8'h12; ram[16'h1003] = 8'hF0;
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_both();
        test_back_to_back();
        test_rollback();
        test_io_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
